// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU operation scheduler and its arbiter:
//   - DATA_W_DEF : default operand/result width
//   - OP_ADD..OP_CMP : 3-bit opcode values forwarded to the ALU unchanged
//   - state_e : scheduler FSM encoding (IDLE, EXEC, RESP)
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W_DEF = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_DIV = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// ----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter. The requester that was NOT granted last wins a
// contention; a sole requester always wins. last_grant only moves when the
// caller reports an accepted transfer, so a grant that is not taken does not
// disturb fairness.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset (last_grant -> 1)
//   req_i[1:0]   : request vector
//   en_i         : arbitration enabled (grants forced low otherwise)
//   accept_i     : the current grant was taken this cycle
//   grant_o[1:0] : one-hot grant (only for a requesting input)
//   grant_idx_o  : index of the would-be winner
// ----------------------------------------------------------------------------
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       en_i,
    input  logic       accept_i,
    output logic [1:0] grant_o,
    output logic       grant_idx_o
);

    logic last_grant_q;
    logic last_grant_d;
    logic winner;

    always_comb begin
        if (req_i == 2'b11) begin
            winner = ~last_grant_q;
        end else begin
            winner = req_i[1];
        end
    end

    always_comb begin
        grant_o = 2'b00;
        if (en_i) begin
            grant_o = req_i & (winner ? 2'b10 : 2'b01);
        end
        last_grant_d = accept_i ? winner : last_grant_q;
    end

    assign grant_idx_o = winner;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/alu_op_scheduler.sv
// ----------------------------------------------------------------------------
// alu_op_scheduler
// Shares one combinational ALU between two requesters. In IDLE a round-robin
// winner is offered ready; on accept its operands/opcode are latched and held
// on the ALU for ALU_LATENCY cycles (EXEC), the result and carry are captured
// on the last EXEC cycle and returned on the owner's response channel (RESP).
// Ports:
//   clk, reset                      : clock, asynchronous active-high reset
//   reqN_valid/ready/a/b/op         : request channel of requester N
//   rspN_valid/ready/data/carry     : response channel of requester N
//   alu_a, alu_b, alu_sel           : registered operands/select to the ALU
//   alu_out, alu_carry              : ALU result
//   busy                            : high in EXEC or RESP
// Optional build macro ALU_SCHED_STATS_EN adds saturating 16-bit counters
//   ops0_count, ops1_count (response handshakes) and contention_count.
// ----------------------------------------------------------------------------
module alu_op_scheduler
    import alu_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ALU_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [2:0]        req0_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp0_carry,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [2:0]        req1_op,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              rsp1_carry,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry,
    output logic              busy
`ifdef ALU_SCHED_STATS_EN
    ,
    output logic [15:0]       ops0_count,
    output logic [15:0]       ops1_count,
    output logic [15:0]       contention_count
`endif
);

    localparam int              CNT_W     = 4;
    localparam logic [CNT_W-1:0] LAST_EXEC = CNT_W'(ALU_LATENCY - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [2:0]        op_q, op_d;
    logic              owner_q, owner_d;
    logic              carry_q, carry_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [1:0]        grant;
    logic              grant_idx;
    logic              accept;
    logic              rsp0_fire, rsp1_fire;

    rr_arbiter2 u_arb (
        .clk         (clk),
        .reset       (reset),
        .req_i       ({req1_valid, req0_valid}),
        .en_i        (state_q == ST_IDLE),
        .accept_i    (accept),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    // A grant is only ever given to a valid requester, so any grant is an accept.
    assign accept     = |grant;
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    assign rsp0_valid = (state_q == ST_RESP) && !owner_q;
    assign rsp1_valid = (state_q == ST_RESP) &&  owner_q;
    assign rsp0_fire  = rsp0_valid && rsp0_ready;
    assign rsp1_fire  = rsp1_valid && rsp1_ready;

    // Both channels show the captured result; only the owner's valid is raised.
    assign rsp0_data  = res_q;
    assign rsp1_data  = res_q;
    assign rsp0_carry = carry_q;
    assign rsp1_carry = carry_q;

    // ALU inputs come straight from the latches, so they only move on accept.
    assign alu_a   = a_q;
    assign alu_b   = b_q;
    assign alu_sel = op_q;
    assign busy    = (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        owner_d = owner_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d     = grant_idx ? req1_a  : req0_a;
                    b_d     = grant_idx ? req1_b  : req0_b;
                    op_d    = grant_idx ? req1_op : req0_op;
                    owner_d = grant_idx;
                    cnt_d   = '0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q == LAST_EXEC) begin
                    res_d   = alu_out;
                    carry_d = alu_carry;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp0_fire || rsp1_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            owner_q <= 1'b0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            owner_q <= owner_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef ALU_SCHED_STATS_EN
    logic [15:0] ops0_q, ops1_q, cont_q;
    logic        cont_now;

    assign cont_now = (state_q == ST_IDLE) && req0_valid && req1_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ops0_q <= '0;
            ops1_q <= '0;
            cont_q <= '0;
        end else begin
            if (rsp0_fire && (ops0_q != 16'hFFFF)) ops0_q <= ops0_q + 16'd1;
            if (rsp1_fire && (ops1_q != 16'hFFFF)) ops1_q <= ops1_q + 16'd1;
            if (cont_now  && (cont_q != 16'hFFFF)) cont_q <= cont_q + 16'd1;
        end
    end

    assign ops0_count       = ops0_q;
    assign ops1_count       = ops1_q;
    assign contention_count = cont_q;
`endif

endmodule

// File: tb/tb_alu_op_scheduler.sv
`timescale 1ns/1ps
module tb_alu_op_scheduler;
    import alu_pkg::*;

    localparam int LAT = 3;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
    } op_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic        owner;
        logic [7:0]  data;
        logic        carry;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready, rsp_carry;
    logic [7:0] req_a [2];
    logic [7:0] req_b [2];
    logic [2:0] req_op [2];
    logic [7:0] rsp_data [2];
    logic [7:0] alu_a, alu_b, alu_out;
    logic [2:0] alu_sel;
    logic       alu_carry, busy;
`ifdef ALU_SCHED_STATS_EN
    logic [15:0] ops0_count, ops1_count, contention_count;
`endif

    // Reference ALU: {carry, data}. Also serves as the ALU the DUT drives.
    function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        case (op)
            OP_ADD:  return {1'b0, a} + {1'b0, b};
            OP_SUB:  return {a < b, a - b};
            OP_AND:  return {1'b0, a & b};
            OP_OR:   return {1'b0, a | b};
            OP_XOR:  return {1'b0, a ^ b};
            OP_MUL:  return {|p[15:8], p[7:0]};
            OP_DIV:  return (b == 8'd0) ? {1'b1, 8'h00} : {1'b0, a / b};
            default: return {a < b, 6'b0, a < b, a == b};
        endcase
    endfunction

    function automatic op_t mk(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        op_t o;
        o.a = a; o.b = b; o.op = op;
        return o;
    endfunction

    assign {alu_carry, alu_out} = alu_ref(alu_a, alu_b, alu_sel);

    alu_op_scheduler #(.DATA_W(8), .ALU_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req_valid[0]), .req0_ready(req_ready[0]), .req0_a(req_a[0]),
        .req0_b(req_b[0]), .req0_op(req_op[0]),
        .rsp0_valid(rsp_valid[0]), .rsp0_ready(rsp_ready[0]), .rsp0_data(rsp_data[0]),
        .rsp0_carry(rsp_carry[0]),
        .req1_valid(req_valid[1]), .req1_ready(req_ready[1]), .req1_a(req_a[1]),
        .req1_b(req_b[1]), .req1_op(req_op[1]),
        .rsp1_valid(rsp_valid[1]), .rsp1_ready(rsp_ready[1]), .rsp1_data(rsp_data[1]),
        .rsp1_carry(rsp_carry[1]),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry(alu_carry), .busy(busy)
`ifdef ALU_SCHED_STATS_EN
        , .ops0_count(ops0_count), .ops1_count(ops1_count),
        .contention_count(contention_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // An op is "in flight" from accept until its response handshake; its
    // response is due LAT+1 cycles after the accept cycle.
    int         cyc = 0;
    bit         m_inflight = 0;
    bit         m_owner = 0;
    int         m_k = 0;          // cycles elapsed since accept
    logic       m_last = 1'b1;    // last granted requester
    logic [8:0] m_res = '0;
    logic [7:0] m_ha = '0, m_hb = '0;
    logic [2:0] m_hs = '0;
    int         m_ops [2] = '{0, 0};
    int         m_cont = 0;
    int         m_drop = 0;
    bit         fired [2] = '{0, 0};
    ev_t        acc_log [$];
    ev_t        rsp_log [$];

    always @(negedge clk) begin
        logic [1:0] e_ready, e_rv;
        logic       w;
        ev_t        ev;
        cyc++;
        if (reset) begin
            if (m_inflight) m_drop++;
            m_inflight = 0; m_last = 1'b1; m_k = 0; m_res = '0;
            m_ha = '0; m_hb = '0; m_hs = '0;
            m_ops = '{0, 0}; m_cont = 0; fired = '{0, 0};
            chk("rst_rsp_data", 32'({rsp_carry, rsp_data[0], rsp_data[1]}), 32'd0);
        end
        e_ready = 2'b00;
        e_rv    = 2'b00;
        w = (req_valid == 2'b11) ? ~m_last : req_valid[1];
        if (!m_inflight && req_valid[w]) e_ready[w] = 1'b1;
        if (m_inflight && m_k > LAT) e_rv[m_owner] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
        chk("busy", 32'(busy), 32'(m_inflight));
        chk("alu_ops", 32'({alu_a, alu_b, alu_sel}), 32'({m_ha, m_hb, m_hs}));
        if (e_rv != 2'b00)
            chk("rsp_payload", 32'({rsp_carry[m_owner], rsp_data[m_owner]}), 32'(m_res));
        if (!reset) begin
            fired[0] = req_valid[0] && req_ready[0];
            fired[1] = req_valid[1] && req_ready[1];
            if (!m_inflight) begin
                if (req_valid == 2'b11) m_cont++;
                if (req_valid[w]) begin
                    m_inflight = 1; m_owner = w; m_last = w; m_k = 1;
                    m_ha = req_a[w]; m_hb = req_b[w]; m_hs = req_op[w];
                    m_res = alu_ref(req_a[w], req_b[w], req_op[w]);
                    ev.cyc = 32'(cyc); ev.owner = w; ev.data = '0; ev.carry = 1'b0;
                    acc_log.push_back(ev);
                end
            end else if (m_k > LAT) begin
                if (rsp_ready[m_owner]) begin
                    m_inflight = 0;
                    m_ops[m_owner]++;
                    ev.cyc = 32'(cyc); ev.owner = m_owner;
                    ev.data = m_res[7:0]; ev.carry = m_res[8];
                    rsp_log.push_back(ev);
                end
            end else begin
                m_k++;
            end
        end
    end

    // ---------------- stimulus engine ----------------
    op_t      q0 [$];
    op_t      q1 [$];
    bit       gaps = 0;
    bit       rdy_rand = 0;
    bit [1:0] rdy_force = 2'b11;

    always @(posedge clk) begin
        bit held;
        #1;
        if (fired[0] && q0.size() > 0) void'(q0.pop_front());
        if (fired[1] && q1.size() > 0) void'(q1.pop_front());
        held = req_valid[0] && !fired[0];
        req_valid[0] = !reset && q0.size() > 0 && (held || !gaps || $urandom_range(0, 2) == 0);
        held = req_valid[1] && !fired[1];
        req_valid[1] = !reset && q1.size() > 0 && (held || !gaps || $urandom_range(0, 2) == 0);
        fired = '{0, 0};
        if (q0.size() > 0) begin
            req_a[0] = q0[0].a; req_b[0] = q0[0].b; req_op[0] = q0[0].op;
        end else begin
            req_a[0] = 8'($urandom); req_b[0] = 8'($urandom); req_op[0] = 3'($urandom);
        end
        if (q1.size() > 0) begin
            req_a[1] = q1[0].a; req_b[1] = q1[0].b; req_op[1] = q1[0].op;
        end else begin
            req_a[1] = 8'($urandom); req_b[1] = 8'($urandom); req_op[1] = 3'($urandom);
        end
        rsp_ready[0] = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force[0];
        rsp_ready[1] = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force[1];
    end

    task automatic wait_acc(input int target, input int budget, input string name);
        int i = 0;
        while (acc_log.size() < target && i < budget) begin
            @(posedge clk);
            i++;
        end
        chk(name, 32'(acc_log.size() >= target), 32'd1);
    endtask

    task automatic wait_rsp(input int target, input int budget, input string name);
        int i = 0;
        while (rsp_log.size() < target && i < budget) begin
            @(posedge clk);
            i++;
        end
        chk(name, 32'(rsp_log.size() >= target), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int na, nr, i;
        reset = 1'b1;
        req_valid = 2'b00; rsp_ready = 2'b00;
        req_a = '{8'd0, 8'd0}; req_b = '{8'd0, 8'd0}; req_op = '{3'd0, 3'd0};
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        // literal expectations pinning the reference ALU
        chk("ref_add", 32'(alu_ref(8'd200, 8'd100, OP_ADD)), 32'h12C);
        chk("ref_sub", 32'(alu_ref(8'd5, 8'd3, OP_SUB)), 32'h002);
        chk("ref_xor", 32'(alu_ref(8'hF0, 8'h0F, OP_XOR)), 32'h0FF);
        chk("ref_div0", 32'(alu_ref(8'd9, 8'd0, OP_DIV)), 32'h100);

        // single op: add 200+100
        q0.push_back(mk(8'd200, 8'd100, OP_ADD));
        wait_rsp(1, 40, "single_done");
        if (rsp_log.size() >= 1 && acc_log.size() >= 1) begin
            chk("single_owner", 32'(rsp_log[0].owner), 32'd0);
            chk("single_data", 32'(rsp_log[0].data), 32'd44);
            chk("single_carry", 32'(rsp_log[0].carry), 32'd1);
            chk("single_latency", rsp_log[0].cyc - acc_log[0].cyc, 32'(LAT + 1));
        end

        // contention from reset: req0 wins first
        @(posedge clk); #2 reset = 1'b1;
        q0.push_back(mk(8'd5, 8'd3, OP_SUB));
        q1.push_back(mk(8'hF0, 8'h0F, OP_XOR));
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        nr = rsp_log.size();
        wait_rsp(nr + 2, 60, "cont_done");
        if (rsp_log.size() >= nr + 2) begin
            chk("cont_first_owner", 32'(rsp_log[nr].owner), 32'd0);
            chk("cont_first_data", 32'(rsp_log[nr].data), 32'd2);
            chk("cont_second_owner", 32'(rsp_log[nr+1].owner), 32'd1);
            chk("cont_second_data", 32'(rsp_log[nr+1].data), 32'hFF);
        end

        // round-robin with both continuously valid
        na = acc_log.size();
        for (int k = 0; k < 3; k++) begin
            q0.push_back(mk(8'(k), 8'd7, OP_OR));
            q1.push_back(mk(8'(k), 8'd9, OP_AND));
        end
        wait_acc(na + 6, 200, "rr_done");
        if (acc_log.size() >= na + 6)
            for (int k = 0; k < 6; k++) chk($sformatf("rr_grant%0d", k),
                                            32'(acc_log[na+k].owner), 32'(k % 2));
        wait_rsp(rsp_log.size() + 1, 40, "rr_drain");
        repeat (4) @(posedge clk);

        // back-pressure on rsp1 with div by zero
        rdy_force = 2'b01;
        na = acc_log.size();
        nr = rsp_log.size();
        q1.push_back(mk(8'd9, 8'd0, OP_DIV));
        wait_acc(na + 1, 20, "bp_accept");
        q0.push_back(mk(8'd3, 8'd4, OP_MUL));
        i = 0;
        do begin
            @(negedge clk); #1; i++;
        end while (!rsp_valid[1] && i < 20);
        chk("bp_seen", 32'(rsp_valid[1]), 32'd1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 32'(rsp_valid[1]), 32'd1);
            chk("bp_data", 32'(rsp_data[1]), 32'd0);
            chk("bp_carry", 32'(rsp_carry[1]), 32'd1);
            chk("bp_no_accept", 32'(req_ready), 32'd0);
            @(negedge clk); #1;
        end
        rdy_force = 2'b11;
        wait_rsp(nr + 1, 20, "bp_handshake");
        wait_acc(na + 2, 20, "bp_next_accept");
        if (rsp_log.size() >= nr + 1 && acc_log.size() >= na + 2)
            chk("bp_accept_after_hs", 32'(acc_log[na+1].cyc > rsp_log[nr].cyc), 32'd1);
        wait_rsp(nr + 2, 40, "bp_drain");
        repeat (3) @(posedge clk);

        // reset during EXEC cycle 2
        nr = rsp_log.size();
        na = acc_log.size();
        q0.push_back(mk(8'd1, 8'd2, OP_ADD));
        wait_acc(na + 1, 20, "rst_accept");
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_alu", 32'({alu_a, alu_b, alu_sel}), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        q0.push_back(mk(8'd50, 8'd8, OP_SUB));
        q1.push_back(mk(8'hAA, 8'h0F, OP_AND));
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        chk("rst_no_rsp", 32'(rsp_log.size()), 32'(nr));
        na = acc_log.size();
        wait_rsp(nr + 2, 60, "rst_after_done");
        if (rsp_log.size() >= nr + 2 && acc_log.size() >= na + 1) begin
            chk("rst_grant_req0", 32'(acc_log[na].owner), 32'd0);
            chk("rst_first_data", 32'(rsp_log[nr].data), 32'd42);
            chk("rst_second_data", 32'(rsp_log[nr+1].data), 32'h0A);
        end

        // randomized traffic
        gaps = 1; rdy_rand = 1;
        for (int k = 0; k < 300; k++) begin
            op_t o;
            o = mk(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 3) == 0) o.b = 8'd0;
            if ($urandom_range(0, 1) == 0) q0.push_back(o);
            else q1.push_back(o);
        end
        i = 0;
        while ((q0.size() > 0 || q1.size() > 0 || m_inflight) && i < 20000) begin
            @(posedge clk);
            i++;
        end
        chk("rand_drained", 32'(i < 20000), 32'd1);
        repeat (4) @(negedge clk);
        chk("all_answered", 32'(rsp_log.size() + m_drop), 32'(acc_log.size()));
`ifdef ALU_SCHED_STATS_EN
        chk("ops0_count", 32'(ops0_count), 32'(m_ops[0]));
        chk("ops1_count", 32'(ops1_count), 32'(m_ops[1]));
        chk("contention_count", 32'(contention_count), 32'(m_cont));
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
